// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch bounce emulator.
// Holds the FSM state encoding and the LFSR polynomial/seed defaults.
package bounce_pkg;

    typedef enum logic [1:0] {
        SETTLED_LO = 2'd0,
        BOUNCE_UP  = 2'd1,
        SETTLED_HI = 2'd2,
        BOUNCE_DN  = 2'd3
    } bounce_state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One right-shifting Galois step: feedback taps are applied when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/switch_bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR supplying pseudo-random dwell times.
// An all-zero seed would lock the register, so it is swapped for the default seed.
module lfsr16
    import bounce_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] seed_eff;
    logic [15:0] q_q;

    assign seed_eff = (seed == 16'h0000) ? DEFAULT_SEED : seed;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= seed_eff;
        end else begin
            q_q <= lfsr_step(q_q);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Mechanical switch emulator: turns a clean level into a chattering output that
// toggles 2*K extra times with pseudo-random dwell times before settling.
module switch_bounce_gen
    import bounce_pkg::*;
#(
    parameter int          DWELL_W = 4,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       db_in,
    input  logic       en,
    input  logic [7:0] bounce_len,
    output logic       sw_out,
    output logic       busy
);

    localparam logic [DWELL_W:0] DWELL_ONE = (DWELL_W + 1)'(1);

    bounce_state_t    state_q, state_d;
    logic [8:0]       rem_q, rem_d;
    logic [DWELL_W:0] dwell_q, dwell_d;
    logic             sw_q, sw_d;
    logic [15:0]      lfsr_q;
    logic [DWELL_W:0] dwell_reload;
    logic             target;
    logic             unused_lfsr_hi;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    // Only the low bits set the dwell; the rest of the LFSR just feeds the sequence.
    assign unused_lfsr_hi = ^lfsr_q[15:DWELL_W];
    assign dwell_reload   = (DWELL_W + 1)'(lfsr_q[DWELL_W-1:0]) + DWELL_ONE;
    assign target         = (state_q == BOUNCE_UP);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dwell_d = dwell_q;
        sw_d    = sw_q;
        unique case (state_q)
            SETTLED_LO: begin
                if (db_in) begin
                    sw_d = 1'b1;
                    if (en && (bounce_len != 8'd0)) begin
                        state_d = BOUNCE_UP;
                        rem_d   = {bounce_len, 1'b0};
                        dwell_d = dwell_reload;
                    end else begin
                        state_d = SETTLED_HI;
                    end
                end
            end
            SETTLED_HI: begin
                if (!db_in) begin
                    sw_d = 1'b0;
                    if (en && (bounce_len != 8'd0)) begin
                        state_d = BOUNCE_DN;
                        rem_d   = {bounce_len, 1'b0};
                        dwell_d = dwell_reload;
                    end else begin
                        state_d = SETTLED_LO;
                    end
                end
            end
            BOUNCE_UP, BOUNCE_DN: begin
                if (db_in != target) begin
                    // Input reversed mid-chatter: snap straight to the new level.
                    state_d = db_in ? SETTLED_HI : SETTLED_LO;
                    sw_d    = db_in;
                    rem_d   = 9'd0;
                    dwell_d = '0;
                end else if (dwell_q > DWELL_ONE) begin
                    dwell_d = dwell_q - DWELL_ONE;
                end else if (rem_q != 9'd0) begin
                    sw_d    = ~sw_q;
                    rem_d   = rem_q - 9'd1;
                    dwell_d = dwell_reload;
                end else begin
                    state_d = target ? SETTLED_HI : SETTLED_LO;
                    dwell_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SETTLED_LO;
            rem_q   <= 9'd0;
            dwell_q <= '0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dwell_q <= dwell_d;
            sw_q    <= sw_d;
        end
    end

    assign sw_out = sw_q;
    assign busy   = (state_q == BOUNCE_UP) || (state_q == BOUNCE_DN);

endmodule
